// File: rtl/mem_copy_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma_pkg
// Description : Shared widths, FSM state encoding and mode constants for the
//               memory copy / fill DMA engine.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_copy_dma_pkg;

  localparam int ADDR_W  = 10;    // memory word-address width
  localparam int DATA_W  = 16;    // memory word width
  localparam int LEN_W   = 11;    // transfer length width (0..1024)
  localparam int MAX_LEN = 1024;  // longest transfer; larger requests are clamped

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Requests longer than the address space would revisit words, so cap them.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_copy_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma_if
// Description : Control and RAM bus bundle of the DMA engine. The slave
//               modport is the engine; the master modport is its environment
//               (requester plus RAM).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_copy_dma_if;
  import mem_copy_dma_pkg::*;

  // request side
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] fill_value;
  // status side
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;
  // RAM side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output start, mode, src_addr, dst_addr, length, fill_value, mem_read_data,
    input  busy, done, words_done, mem_addr, mem_write_data, mem_write_enable
  );

  modport slave (
    input  start, mode, src_addr, dst_addr, length, fill_value, mem_read_data,
    output busy, done, words_done, mem_addr, mem_write_data, mem_write_enable
  );

endinterface
`default_nettype wire

// File: rtl/mem_copy_dma_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : dma_addr_counter
// Description : Word-address pointer with synchronous load and increment.
//               Wraps modulo 2^WIDTH, so a range may cross the top of memory.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_addr_counter
  import mem_copy_dma_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_value,
  input  wire logic             inc,
  output logic      [WIDTH-1:0] count
);

  // Load wins over increment; the add simply overflows back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (load) count <= load_value;
    else if (inc)  count <= count + WIDTH'(1);
  end

endmodule
`default_nettype wire

// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma
// Description : Single-channel DMA that copies a block of RAM words in
//               ascending order (read, then write, per word) or fills a block
//               with a constant (one write per cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_dma
  import mem_copy_dma_pkg::*;
(
  input  wire logic    clk,
  input  wire logic    reset,
  mem_copy_dma_if.slave bus
);

  state_t            state;
  logic              mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] buffer;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  words_done_q;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              ptr_load;
  logic              ptr_inc;

  // Pointers load on an accepted request and advance after every store.
  assign ptr_load = (state == IDLE) && bus.start;
  assign ptr_inc  = (state == WRITE) || (state == FILL);

  dma_addr_counter #(.WIDTH(ADDR_W)) u_src_ptr (
    .clk        (clk),
    .reset      (reset),
    .load       (ptr_load),
    .load_value (bus.src_addr),
    .inc        (ptr_inc),
    .count      (src_ptr)
  );

  dma_addr_counter #(.WIDTH(ADDR_W)) u_dst_ptr (
    .clk        (clk),
    .reset      (reset),
    .load       (ptr_load),
    .load_value (bus.dst_addr),
    .inc        (ptr_inc),
    .count      (dst_ptr)
  );

  // Transfer sequencer: latches the request and walks READ/WRITE or FILL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mode_q       <= MODE_COPY;
      fill_q       <= '0;
      buffer       <= '0;
      remaining    <= '0;
      words_done_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q       <= bus.mode;
            fill_q       <= bus.fill_value;
            remaining    <= clamp_len(bus.length);
            words_done_q <= '0;
            if (bus.length == '0)           state <= DONE;
            else if (bus.mode == MODE_FILL) state <= FILL;
            else                            state <= READ;
          end
        end
        READ: begin
          buffer <= bus.mem_read_data;
          state  <= WRITE;
        end
        WRITE, FILL: begin
          words_done_q <= words_done_q + LEN_W'(1);
          remaining    <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1))     state <= DONE;
          else if (mode_q == MODE_FILL)   state <= FILL;
          else                            state <= READ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.words_done = words_done_q;

  // RAM strobes come only from registers so they settle before the falling edge.
  always_comb begin
    bus.mem_addr         = '0;
    bus.mem_write_data   = '0;
    bus.mem_write_enable = 1'b0;
    case (state)
      READ: begin
        bus.mem_addr = src_ptr;
      end
      WRITE: begin
        bus.mem_addr         = dst_ptr;
        bus.mem_write_data   = buffer;
        bus.mem_write_enable = 1'b1;
      end
      FILL: begin
        bus.mem_addr         = dst_ptr;
        bus.mem_write_data   = fill_q;
        bus.mem_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_dma
// Description : Self-checking bench for mem_copy_dma. A RAM preloaded with
//               Memory[i] = i sits on the bus; a word-level model predicts
//               the per-cycle bus activity of every accepted transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_dma;
  import mem_copy_dma_pkg::*;

  typedef enum int {K_READ, K_WRITE, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    addr;
    int    data;
    int    wd;
  } step_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_copy_dma_if bus();

  mem_copy_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [DATA_W-1:0] ram [1024];
  bit                ram_loaded = 1'b0;
  int                ref_mem [1024];
  step_t             trace_q [$];
  int                last_wd;
  int                checks   = 0;
  int                failures = 0;

  // RAM: combinational read, store committed on the falling edge.
  assign bus.mem_read_data = ram[bus.mem_addr];
  always @(negedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] <= DATA_W'(i);
      ram_loaded <= 1'b1;
    end else if (bus.mem_write_enable) begin
      ram[bus.mem_addr] <= bus.mem_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bus activity of one transfer, derived word by word.
  task automatic build_trace(input bit m, input int src, input int dst, input int len, input int fill);
    int L;
    int v;
    int sa;
    int da;
    int scratch [1024];
    scratch = ref_mem;
    L = (len > 1024) ? 1024 : len;
    for (int i = 0; i < L; i++) begin
      da = (dst + i) % 1024;
      if (m == MODE_COPY) begin
        sa = (src + i) % 1024;
        v  = scratch[sa];
        trace_q.push_back('{K_READ, sa, 0, i});
      end else begin
        v = fill & 16'hFFFF;
      end
      trace_q.push_back('{K_WRITE, da, v, i});
      scratch[da] = v;
    end
    trace_q.push_back('{K_DONE, 0, 0, L});
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  initial begin
    step_t s;
    for (int i = 0; i < 1024; i++) ref_mem[i] = i;
    last_wd = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        trace_q.delete();
        last_wd = 0;
      end
      if (!reset && trace_q.size() > 0) begin
        s = trace_q.pop_front();
        check("busy", 32'(bus.busy), 1);
        check("done", 32'(bus.done), 32'(s.kind == K_DONE));
        check("mem_write_enable", 32'(bus.mem_write_enable), 32'(s.kind == K_WRITE));
        if (s.kind != K_DONE) check("mem_addr", 32'(bus.mem_addr), s.addr);
        if (s.kind == K_WRITE) begin
          check("mem_write_data", 32'(bus.mem_write_data), s.data);
          ref_mem[s.addr] = s.data;
        end
        check("words_done", 32'(bus.words_done), s.wd);
        if (s.kind == K_DONE) last_wd = s.wd;
      end else begin
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_done", 32'(bus.done), 0);
        check("idle_we", 32'(bus.mem_write_enable), 0);
        check("idle_addr", 32'(bus.mem_addr), 0);
        check("idle_wdata", 32'(bus.mem_write_data), 0);
        check("idle_words_done", 32'(bus.words_done), last_wd);
      end
    end
  end

  // Issue one request from IDLE, return cycles from acceptance to done.
  task automatic run_xfer(input bit m, input int src, input int dst, input int len,
                          input int fill, input bit poke, output int lat);
    bus.mode       = m;
    bus.src_addr   = ADDR_W'(src);
    bus.dst_addr   = ADDR_W'(dst);
    bus.length     = LEN_W'(len);
    bus.fill_value = DATA_W'(fill);
    bus.start      = 1'b1;
    @(posedge clk);
    build_trace(m, src, dst, len, fill);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (poke && n == 2) begin
        bus.mode     = MODE_COPY;
        bus.src_addr = 10'h000;
        bus.dst_addr = 10'h300;
        bus.length   = 11'd4;
        bus.start    = 1'b1;
      end
      if (poke && n == 3) bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check("xfer_done_seen", 32'(lat != 0), 1);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int mism;
    int len;
    bus.start      = 1'b0;
    bus.mode       = MODE_COPY;
    bus.src_addr   = '0;
    bus.dst_addr   = '0;
    bus.length     = '0;
    bus.fill_value = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Plain copy
    run_xfer(MODE_COPY, 'h010, 'h200, 4, 0, 1'b0, lat);
    check("copy4_latency", lat, 9);
    check("copy4_words_done", 32'(bus.words_done), 4);
    for (int i = 0; i < 4; i++) check("copy4_mem", 32'(ram['h200 + i]), 'h10 + i);

    // Fill across the top of memory
    run_xfer(MODE_FILL, 0, 'h3FE, 4, 'hBEEF, 1'b0, lat);
    check("fill4_latency", lat, 5);
    check("fill4_mem_3fe", 32'(ram['h3FE]), 'hBEEF);
    check("fill4_mem_3ff", 32'(ram['h3FF]), 'hBEEF);
    check("fill4_mem_000", 32'(ram['h000]), 'hBEEF);
    check("fill4_mem_001", 32'(ram['h001]), 'hBEEF);
    check("fill4_mem_002", 32'(ram['h002]), 'h0002);

    // Zero length
    run_xfer(MODE_COPY, 'h050, 'h150, 0, 0, 1'b0, lat);
    check("len0_latency", lat, 1);
    check("len0_words_done", 32'(bus.words_done), 0);

    // Second start while busy must be ignored
    run_xfer(MODE_COPY, 'h020, 'h220, 4, 0, 1'b1, lat);
    check("poke_latency", lat, 9);
    check("poke_mem_300", 32'(ram['h300]), 'h300);
    check("poke_mem_223", 32'(ram['h223]), 'h23);

    // Reset during the store of word 2
    bus.mode     = MODE_COPY;
    bus.src_addr = 10'h040;
    bus.dst_addr = 10'h240;
    bus.length   = 11'd4;
    bus.start    = 1'b1;
    @(posedge clk);
    build_trace(MODE_COPY, 'h040, 'h240, 4, 0);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_pre_we", 32'(bus.mem_write_enable), 1);
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_we", 32'(bus.mem_write_enable), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_words_done", 32'(bus.words_done), 0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mem_240", 32'(ram['h240]), 'h40);
    check("rst_mem_241", 32'(ram['h241]), 'h241);
    check("rst_mem_242", 32'(ram['h242]), 'h242);

    // Overlapping ascending copy smears the first source word
    run_xfer(MODE_COPY, 'h100, 'h101, 3, 0, 1'b0, lat);
    for (int i = 1; i <= 3; i++) check("smear_mem", 32'(ram['h100 + i]), 'h100);

    // Randomized transfers
    for (int t = 0; t < 30; t++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
      run_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1023)), len, int'($urandom_range(0, 65535)),
               1'b0, lat);
    end

    // Over-long requests are clamped to 1024 words
    run_xfer(MODE_FILL, 0, int'($urandom_range(0, 1023)), 2047, 'h5A5A, 1'b0, lat);
    check("clamp_fill_latency", lat, 1025);
    check("clamp_fill_words_done", 32'(bus.words_done), 1024);
    run_xfer(MODE_COPY, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1030, 0, 1'b0, lat);
    check("clamp_copy_latency", lat, 2049);
    check("clamp_copy_words_done", 32'(bus.words_done), 1024);

    // Whole-memory image against the model
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== DATA_W'(ref_mem[i])) mism++;
    check("ram_image_mismatches", mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
